// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one byte-wide UART transmitter among NUM_REQ producers.
// Each frame is an optional ID header byte followed by the latched word, least-significant byte first.
module uart_tx_sched #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned WORD_BYTES  = 4,
    parameter int unsigned SEND_HEADER = 1,
    parameter logic [7:0]  HEADER_BASE = 8'hA0
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*WORD_BYTES*8-1:0] req_data,
    output logic [NUM_REQ-1:0]              ack,
    output logic                            tx_en,
    output logic [7:0]                      tx_data,
    input  logic                            tx_busy,
    output logic [3:0]                      grant_id,
    output logic                            active
);
    localparam int unsigned WORD_W    = WORD_BYTES * 8;
    localparam int unsigned HDR       = (SEND_HEADER != 0) ? 1 : 0;
    localparam int unsigned FRAME_LEN = WORD_BYTES + HDR;
    localparam int unsigned CNT_W     = $clog2(WORD_BYTES + 2);
    localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [WORD_W-1:0]   shreg, shreg_nxt;
    logic [3:0]          ptr, ptr_nxt;
    logic [NUM_REQ-1:0]  ack_nxt;
    logic                tx_en_nxt;
    logic [7:0]          tx_data_nxt;
    logic [3:0]          grant_nxt;
    logic                active_nxt;

    logic                found;
    logic [3:0]          winner;
    int unsigned         idx;
    logic [WORD_W-1:0]   word_sel;
    logic                hdr_pending;
    logic [7:0]          first_byte;
    logic [7:0]          cur_byte;

    // Round-robin search: first requester at or after the pointer, wrapping at NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[IDX_W'(idx)]) begin
                found  = 1'b1;
                winner = 4'(idx);
            end
        end
    end

    always_comb begin
        word_sel = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (winner == 4'(j)) begin
                word_sel = req_data[j*WORD_W +: WORD_W];
            end
        end
    end

    // The header occupies the extra count slot above the payload bytes and never shifts the word.
    assign hdr_pending = (HDR != 0) && (cnt == CNT_W'(WORD_BYTES + 1));
    assign first_byte  = (HDR != 0) ? (HEADER_BASE | 8'(winner)) : word_sel[7:0];
    assign cur_byte    = hdr_pending ? (HEADER_BASE | 8'(grant_id)) : shreg[7:0];

    // A grant seen with the line free strobes the first byte straight away; otherwise LOAD waits.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        shreg_nxt   = shreg;
        ptr_nxt     = ptr;
        ack_nxt     = '0;
        tx_en_nxt   = 1'b0;
        tx_data_nxt = tx_data;
        grant_nxt   = grant_id;
        active_nxt  = active;
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt  = winner;
                    active_nxt = 1'b1;
                    cnt_nxt    = CNT_W'(FRAME_LEN);
                    shreg_nxt  = word_sel;
                    if (!tx_busy) begin
                        tx_en_nxt   = 1'b1;
                        tx_data_nxt = first_byte;
                        state_nxt   = WAIT_HI;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                if (!tx_busy) begin
                    tx_en_nxt   = 1'b1;
                    tx_data_nxt = cur_byte;
                    state_nxt   = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_nxt = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (!hdr_pending) begin
                        shreg_nxt = shreg >> 8;
                    end
                    if (cnt == CNT_W'(1)) begin
                        ack_nxt   = NUM_REQ'(1) << grant_id;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            DONE: begin
                ptr_nxt    = (grant_id == 4'(NUM_REQ - 1)) ? 4'd0 : grant_id + 4'd1;
                active_nxt = 1'b0;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            ptr      <= '0;
            ack      <= '0;
            tx_en    <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
            active   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            shreg    <= shreg_nxt;
            ptr      <= ptr_nxt;
            ack      <= ack_nxt;
            tx_en    <= tx_en_nxt;
            tx_data  <= tx_data_nxt;
            grant_id <= grant_nxt;
            active   <= active_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: default 4x4-byte instance plus a headerless 1-byte instance,
// each fed by a transmitter model that holds busy for 20 cycles per strobe.
module tb_uart_tx_sched;
    localparam int unsigned NREQ     = 4;
    localparam int unsigned WB       = 4;
    localparam int          BUSY_LEN = 20;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [NREQ-1:0]      req;
    logic [NREQ*WB*8-1:0] req_data;
    logic [NREQ-1:0]      ack;
    logic                 tx_en;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic [3:0]           grant_id;
    logic                 active;

    logic [NREQ-1:0]      req_b;
    logic [NREQ*8-1:0]    req_data_b;
    logic [NREQ-1:0]      ack_b;
    logic                 tx_en_b;
    logic [7:0]           tx_data_b;
    logic                 tx_busy_b;
    logic [3:0]           grant_id_b;
    logic                 active_b;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   busy_cnt    = 0;
    int   busy_cnt_b  = 0;
    logic stall       = 1'b0;
    logic busy_prev   = 1'b0;

    logic [7:0]      tx_q[$];
    int              txc_q[$];
    logic [NREQ-1:0] ack_q[$];
    int              ackc_q[$];
    int              fall_q[$];

    uart_tx_sched #(.NUM_REQ(NREQ), .WORD_BYTES(WB), .SEND_HEADER(1), .HEADER_BASE(8'hA0)) dut (
        .clk(clk), .resetn(resetn), .req(req), .req_data(req_data), .ack(ack),
        .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id), .active(active)
    );

    uart_tx_sched #(.NUM_REQ(NREQ), .WORD_BYTES(1), .SEND_HEADER(0), .HEADER_BASE(8'hA0)) dut_b (
        .clk(clk), .resetn(resetn), .req(req_b), .req_data(req_data_b), .ack(ack_b),
        .tx_en(tx_en_b), .tx_data(tx_data_b), .tx_busy(tx_busy_b), .grant_id(grant_id_b), .active(active_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter models: busy rises the cycle after a strobe and lasts BUSY_LEN cycles.
    always @(posedge clk) begin
        if (!resetn)             busy_cnt <= 0;
        else if (tx_en)          busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
    end
    always @(posedge clk) begin
        if (!resetn)              busy_cnt_b <= 0;
        else if (tx_en_b)         busy_cnt_b <= BUSY_LEN;
        else if (busy_cnt_b != 0) busy_cnt_b <= busy_cnt_b - 1;
    end
    assign tx_busy   = (busy_cnt != 0) || stall;
    assign tx_busy_b = (busy_cnt_b != 0);

    always @(negedge clk) begin
        if (tx_en) begin
            tx_q.push_back(tx_data);
            txc_q.push_back(cyc);
        end
        if (ack != '0) begin
            ack_q.push_back(ack);
            ackc_q.push_back(cyc);
        end
        if (busy_prev && !tx_busy) fall_q.push_back(cyc);
        busy_prev = tx_busy;
    end

    task automatic clear_logs();
        tx_q.delete();
        txc_q.delete();
        ack_q.delete();
        ackc_q.delete();
        fall_q.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0; req = '0; req_data = '0; req_b = '0; req_data_b = '0; stall = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (ack !== 4'h0) begin miscompares++; $display("FAIL reset_ack got=%h exp=0", ack); end
        vectors++; if (tx_en !== 1'b0) begin miscompares++; $display("FAIL reset_tx_en got=%b exp=0", tx_en); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        vectors++; if (grant_id !== 4'h0) begin miscompares++; $display("FAIL reset_grant got=%h exp=0", grant_id); end
        vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL reset_active got=%b exp=0", active); end
        vectors++; if ({ack_b, tx_en_b, active_b} !== 6'b0) begin
            miscompares++; $display("FAIL reset_b got=%b exp=000000", {ack_b, tx_en_b, active_b});
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        bit got;
        logic [39:0] bytes;
        clear_logs();
        req_data = {$urandom, 32'h11223344, $urandom, $urandom};
        req = 4'b0100;
        n = cyc;
        @(negedge clk);
        vectors++; if (active !== 1'b1) begin miscompares++; $display("FAIL single_active got=%b exp=1", active); end
        vectors++; if (grant_id !== 4'd2) begin miscompares++; $display("FAIL single_grant got=%h exp=2", grant_id); end
        vectors++; if ({tx_en, tx_data} !== {1'b1, 8'hA2}) begin
            miscompares++; $display("FAIL single_first_byte got=%b/%h exp=1/a2", tx_en, tx_data);
        end
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (ack != '0) got = 1'b1;
        end
        req = '0;
        vectors++; if (!got) begin miscompares++; $display("FAIL single_ack_timeout got=none exp=ack"); end
        repeat (3) @(negedge clk);
        vectors++; if (txc_q.size() < 1 || txc_q[0] != n + 1) begin
            miscompares++; $display("FAIL single_first_latency got=%0d exp=%0d", (txc_q.size() > 0) ? txc_q[0] : -1, n + 1);
        end
        vectors++;
        if (tx_q.size() != 5) begin
            miscompares++; $display("FAIL single_len got=%0d exp=5", tx_q.size());
        end else begin
            bytes = {tx_q[0], tx_q[1], tx_q[2], tx_q[3], tx_q[4]};
            vectors++; if (bytes !== 40'hA244332211) begin
                miscompares++; $display("FAIL single_bytes got=%h exp=a244332211", bytes);
            end
        end
        vectors++;
        if (ack_q.size() != 1 || fall_q.size() != 5) begin
            miscompares++; $display("FAIL single_events got=acks %0d falls %0d exp=acks 1 falls 5", ack_q.size(), fall_q.size());
        end else begin
            vectors++; if (ack_q[0] !== 4'b0100) begin miscompares++; $display("FAIL single_ack_val got=%b exp=0100", ack_q[0]); end
            vectors++; if (ackc_q[0] != fall_q[4] + 1) begin
                miscompares++; $display("FAIL single_ack_timing got=%0d exp=%0d", ackc_q[0], fall_q[4] + 1);
            end
            if (txc_q.size() == 5) begin
                for (int k = 0; k < 4; k++) begin
                    vectors++; if (txc_q[k+1] != fall_q[k] + 2) begin
                        miscompares++; $display("FAIL single_interbyte%0d got=%0d exp=%0d", k, txc_q[k+1], fall_q[k] + 2);
                    end
                end
            end
        end
    endtask

    task automatic test_fairness();
        int acks;
        logic [7:0] exp_hdr;
        logic [NREQ-1:0] exp_ack;
        logic [39:0] bytes;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        clear_logs();
        req_data = {32'hDDCCBBAA, 32'h33221100, 32'h87654321, 32'h0F1E2D3C};
        req = 4'b1111;
        acks = 0;
        for (int i = 0; i < 4000 && acks < 6; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                acks++;
                if (acks == 6) req = '0;
            end
        end
        req = '0;
        vectors++; if (acks != 6) begin miscompares++; $display("FAIL fair_ack_count got=%0d exp=6", acks); end
        repeat (3) @(negedge clk);
        vectors++;
        if (tx_q.size() != 30 || ack_q.size() != 6) begin
            miscompares++; $display("FAIL fair_events got=bytes %0d acks %0d exp=bytes 30 acks 6", tx_q.size(), ack_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                exp_hdr = 8'hA0 | 8'(k % 4);
                exp_ack = 4'b0001 << (k % 4);
                vectors++; if (tx_q[5*k] !== exp_hdr) begin
                    miscompares++; $display("FAIL fair_grant%0d got=%h exp=%h", k, tx_q[5*k], exp_hdr);
                end
                vectors++; if (ack_q[k] !== exp_ack) begin
                    miscompares++; $display("FAIL fair_ack%0d got=%b exp=%b", k, ack_q[k], exp_ack);
                end
            end
            for (int k = 0; k < 5; k++) begin
                vectors++; if (txc_q[5*(k+1)] != ackc_q[k] + 2) begin
                    miscompares++; $display("FAIL fair_regrant%0d got=%0d exp=%0d", k, txc_q[5*(k+1)], ackc_q[k] + 2);
                end
            end
            bytes = {tx_q[5], tx_q[6], tx_q[7], tx_q[8], tx_q[9]};
            vectors++; if (bytes !== 40'hA121436587) begin
                miscompares++; $display("FAIL fair_payload1 got=%h exp=a121436587", bytes);
            end
        end
    endtask

    task automatic test_drop();
        bit got;
        logic [39:0] bytes;
        clear_logs();
        req_data[32 +: 32] = 32'hDEADBEEF;
        req = 4'b0010;
        for (int i = 0; i < 400 && tx_q.size() < 2; i++) @(negedge clk);
        req = '0;
        vectors++; if (tx_q.size() < 2) begin miscompares++; $display("FAIL drop_start got=%0d bytes exp=2", tx_q.size()); end
        @(negedge clk);
        vectors++; if (active !== 1'b1) begin miscompares++; $display("FAIL drop_active got=%b exp=1", active); end
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (ack != '0) got = 1'b1;
        end
        vectors++; if (!got) begin miscompares++; $display("FAIL drop_ack_timeout got=none exp=ack"); end
        repeat (3) @(negedge clk);
        vectors++;
        if (tx_q.size() != 5 || ack_q.size() != 1) begin
            miscompares++; $display("FAIL drop_events got=bytes %0d acks %0d exp=bytes 5 acks 1", tx_q.size(), ack_q.size());
        end else begin
            bytes = {tx_q[0], tx_q[1], tx_q[2], tx_q[3], tx_q[4]};
            vectors++; if (bytes !== 40'hA1EFBEADDE) begin miscompares++; $display("FAIL drop_bytes got=%h exp=a1efbeadde", bytes); end
            vectors++; if (ack_q[0] !== 4'b0010) begin miscompares++; $display("FAIL drop_ack_val got=%b exp=0010", ack_q[0]); end
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        logic [39:0] bytes;
        clear_logs();
        req_data[2*32 +: 32] = 32'hCAFEF00D;
        req_data[0 +: 32]    = 32'h0BADC0DE;
        req = 4'b0100;
        for (int i = 0; i < 400 && tx_q.size() < 3; i++) @(negedge clk);
        vectors++; if (tx_q.size() < 3) begin miscompares++; $display("FAIL rmid_start got=%0d bytes exp=3", tx_q.size()); end
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        vectors++; if (tx_en !== 1'b0) begin miscompares++; $display("FAIL rmid_tx_en got=%b exp=0", tx_en); end
        vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL rmid_active got=%b exp=0", active); end
        vectors++; if (ack !== 4'h0) begin miscompares++; $display("FAIL rmid_ack got=%b exp=0000", ack); end
        vectors++; if (grant_id !== 4'h0) begin miscompares++; $display("FAIL rmid_grant got=%h exp=0", grant_id); end
        vectors++; if (ack_q.size() != 0) begin miscompares++; $display("FAIL rmid_no_ack got=%0d exp=0", ack_q.size()); end
        clear_logs();
        resetn = 1'b1;
        req = 4'b1001;
        @(negedge clk);
        vectors++; if ({active, grant_id} !== {1'b1, 4'd0}) begin
            miscompares++; $display("FAIL rmid_regrant got=%b/%h exp=1/0", active, grant_id);
        end
        vectors++; if ({tx_en, tx_data} !== {1'b1, 8'hA0}) begin
            miscompares++; $display("FAIL rmid_first_byte got=%b/%h exp=1/a0", tx_en, tx_data);
        end
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (ack != '0) got = 1'b1;
        end
        req = '0;
        vectors++; if (!got) begin miscompares++; $display("FAIL rmid_ack_timeout got=none exp=ack"); end
        repeat (3) @(negedge clk);
        vectors++;
        if (tx_q.size() != 5 || ack_q.size() != 1) begin
            miscompares++; $display("FAIL rmid_events got=bytes %0d acks %0d exp=bytes 5 acks 1", tx_q.size(), ack_q.size());
        end else begin
            bytes = {tx_q[0], tx_q[1], tx_q[2], tx_q[3], tx_q[4]};
            vectors++; if (bytes !== 40'hA0DEC0AD0B) begin miscompares++; $display("FAIL rmid_bytes got=%h exp=a0dec0ad0b", bytes); end
            vectors++; if (ack_q[0] !== 4'b0001) begin miscompares++; $display("FAIL rmid_ack_val got=%b exp=0001", ack_q[0]); end
        end
    endtask

    task automatic test_busy_stall();
        int seen;
        bit got;
        logic [39:0] bytes;
        clear_logs();
        req_data[3*32 +: 32] = 32'h01020304;
        stall = 1'b1;
        req = 4'b1000;
        @(negedge clk);
        vectors++; if ({active, grant_id} !== {1'b1, 4'd3}) begin
            miscompares++; $display("FAIL stall_grant got=%b/%h exp=1/3", active, grant_id);
        end
        seen = (tx_en === 1'b1) ? 1 : 0;
        repeat (49) begin
            @(negedge clk);
            if (tx_en !== 1'b0) seen++;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL stall_no_strobe got=%0d strobes exp=0", seen); end
        stall = 1'b0;
        @(negedge clk);
        vectors++; if ({tx_en, tx_data} !== {1'b1, 8'hA3}) begin
            miscompares++; $display("FAIL stall_release got=%b/%h exp=1/a3", tx_en, tx_data);
        end
        @(negedge clk);
        vectors++; if (tx_en !== 1'b0) begin miscompares++; $display("FAIL stall_single_strobe got=%b exp=0", tx_en); end
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            if (ack != '0) got = 1'b1;
        end
        req = '0;
        vectors++; if (!got) begin miscompares++; $display("FAIL stall_ack_timeout got=none exp=ack"); end
        repeat (3) @(negedge clk);
        vectors++;
        if (tx_q.size() != 5 || ack_q.size() != 1) begin
            miscompares++; $display("FAIL stall_events got=bytes %0d acks %0d exp=bytes 5 acks 1", tx_q.size(), ack_q.size());
        end else begin
            bytes = {tx_q[0], tx_q[1], tx_q[2], tx_q[3], tx_q[4]};
            vectors++; if (bytes !== 40'hA304030201) begin miscompares++; $display("FAIL stall_bytes got=%h exp=a304030201", bytes); end
            vectors++; if (ack_q[0] !== 4'b1000) begin miscompares++; $display("FAIL stall_ack_val got=%b exp=1000", ack_q[0]); end
        end
    endtask

    task automatic test_header_off();
        int pulses;
        int fall;
        int ackc;
        bit got;
        logic prev;
        logic [NREQ-1:0] ackv;
        req_data_b = {8'h11, 8'h22, 8'h33, 8'h5A};
        req_b = 4'b0001;
        @(negedge clk);
        vectors++; if ({tx_en_b, tx_data_b} !== {1'b1, 8'h5A}) begin
            miscompares++; $display("FAIL hoff_byte got=%b/%h exp=1/5a", tx_en_b, tx_data_b);
        end
        vectors++; if ({active_b, grant_id_b} !== {1'b1, 4'd0}) begin
            miscompares++; $display("FAIL hoff_grant got=%b/%h exp=1/0", active_b, grant_id_b);
        end
        pulses = 1; fall = -100; ackc = -1; got = 1'b0; ackv = '0; prev = tx_busy_b;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (tx_en_b) pulses++;
            if (prev && !tx_busy_b) fall = cyc;
            prev = tx_busy_b;
            if (ack_b != '0) begin
                got = 1'b1; ackv = ack_b; ackc = cyc;
            end
        end
        req_b = '0;
        vectors++; if (!got) begin miscompares++; $display("FAIL hoff_ack_timeout got=none exp=ack"); end
        vectors++; if (ackv !== 4'b0001) begin miscompares++; $display("FAIL hoff_ack_val got=%b exp=0001", ackv); end
        vectors++; if (pulses != 1) begin miscompares++; $display("FAIL hoff_pulses got=%0d exp=1", pulses); end
        vectors++; if (ackc != fall + 1) begin miscompares++; $display("FAIL hoff_ack_timing got=%0d exp=%0d", ackc, fall + 1); end
        repeat (3) @(negedge clk);
        vectors++; if (active_b !== 1'b0) begin miscompares++; $display("FAIL hoff_idle got=%b exp=0", active_b); end
    endtask

    initial begin
        resetn = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_drop();
        test_reset_mid();
        test_busy_stall();
        test_header_off();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
